mem_responder: RTL and testbench



---
 rtl/mem_responder_if.sv | 24 ++
 rtl/mem_responder.sv | 124 ++++++++++++
 tb/tb_mem_responder.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Memory-port bus between the cache controller (master) and backing memory (slave).
// One request is held as a level; the slave answers with single-cycle strobes.
interface mem_responder_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  logic              mem_rd_en;
  logic              mem_wd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wd_data;
  logic [DATA_W-1:0] mem_data;
  logic              mem_data_valid;
  logic              mem_wd_valid;

  modport master (
    output mem_rd_en, mem_wd_en, mem_addr, mem_wd_data,
    input  mem_data, mem_data_valid, mem_wd_valid
  );

  modport slave (
    input  mem_rd_en, mem_wd_en, mem_addr, mem_wd_data,
    output mem_data, mem_data_valid, mem_wd_valid
  );
endinterface

// File: rtl/mem_responder.sv
// Behavioural backing memory: one read-refill or write-back at a time, fixed latency.
// Optional MEM_RESPONDER_PRELOAD_EN fills word[i] = {i, ~i} at time zero.
module mem_responder #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 64,
  parameter int DEPTH      = 1024,
  parameter int RD_LATENCY = 4,
  parameter int WR_LATENCY = 2
) (
  input  logic            clk,
  input  logic            rst,
  mem_responder_if.slave  bus
);

  localparam int         IDX_W  = $clog2(DEPTH);
  localparam logic [3:0] RD_CNT = 4'(RD_LATENCY - 1);
  localparam logic [3:0] WR_CNT = 4'(WR_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, DONE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [3:0]        cnt;
  logic [3:0]        cnt_nxt;
  logic              capture;
  logic              rd_fire;
  logic              wr_fire;
  logic [IDX_W-1:0]  idx_req;
  logic [IDX_W-1:0]  idx_cap;
  logic [DATA_W-1:0] wd_cap;
  logic              addr_unused;

  logic [DATA_W-1:0] mem [DEPTH];

`ifdef MEM_RESPONDER_PRELOAD_EN
  function automatic logic [DATA_W-1:0] preload_word(input int unsigned i);
    logic [31:0] w;
    w = i;
    return DATA_W'({w, ~w});
  endfunction

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = preload_word(i);
  end
`endif

  // Byte offset and bits above the array size are dropped: aligned access, wrap modulo DEPTH.
  assign idx_req     = bus.mem_addr[IDX_W+2:3];
  assign addr_unused = ^{bus.mem_addr[ADDR_W-1:IDX_W+3], bus.mem_addr[2:0]};

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    rd_fire   = 1'b0;
    wr_fire   = 1'b0;
    case (state)
      IDLE: begin
        // Write-back wins so a dirty eviction lands before the refill that follows it.
        if (bus.mem_wd_en) begin
          capture   = 1'b1;
          cnt_nxt   = WR_CNT;
          state_nxt = WR_WAIT;
        end else if (bus.mem_rd_en) begin
          capture   = 1'b1;
          cnt_nxt   = RD_CNT;
          state_nxt = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (cnt == 4'd0) begin
          rd_fire   = 1'b1;
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      WR_WAIT: begin
        if (cnt == 4'd0) begin
          wr_fire   = 1'b1;
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      DONE: begin
        // Re-arm only once the master drops its level request, so it is served once.
        if (!bus.mem_rd_en && !bus.mem_wd_en) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control and response registers: cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state              <= IDLE;
      cnt                <= 4'd0;
      bus.mem_data_valid <= 1'b0;
      bus.mem_wd_valid   <= 1'b0;
      bus.mem_data       <= '0;
    end else begin
      state              <= state_nxt;
      cnt                <= cnt_nxt;
      bus.mem_data_valid <= rd_fire;
      bus.mem_wd_valid   <= wr_fire;
      if (rd_fire) bus.mem_data <= mem[idx_cap];
    end
  end

  // Request capture: later changes on the bus are ignored for the rest of the transaction.
  always_ff @(posedge clk) begin
    if (capture) begin
      idx_cap <= idx_req;
      wd_cap  <= bus.mem_wd_data;
    end
  end

  // Array commits together with the acknowledge; reset leaves contents alone.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[idx_cap] <= wd_cap;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Randomised self-checking bench for mem_responder against an associative-array memory model.
`timescale 1ns/1ps
module tb_mem_responder;

  localparam int DEPTH  = 1024;
  localparam int RD_LAT = 4;
  localparam int WR_LAT = 2;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  logic [63:0] mdl [int unsigned];

  mem_responder_if #(.ADDR_W(32), .DATA_W(64)) bus ();

  mem_responder #(
    .ADDR_W(32), .DATA_W(64), .DEPTH(DEPTH),
    .RD_LATENCY(RD_LAT), .WR_LATENCY(WR_LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    check("strobe_excl", {63'd0, bus.mem_data_valid & bus.mem_wd_valid}, 64'd0);
  end

  function automatic int unsigned word_of(input logic [31:0] addr);
    return (addr / 8) % DEPTH;
  endfunction

  // Expected word for a read; returns 0 when the word content is unknown.
  function automatic bit expect_word(input int unsigned idx, output logic [63:0] exp);
    exp = '0;
    if (mdl.exists(idx)) begin
      exp = mdl[idx];
      return 1'b1;
    end
`ifdef MEM_RESPONDER_PRELOAD_EN
    exp = {idx, ~idx};
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic xact(input bit wr, input logic [31:0] addr, input logic [63:0] wdata, input int hold);
    int          lat;
    int          extra;
    logic [63:0] rdata;
    logic [63:0] exp;
    int unsigned idx;
    idx             = word_of(addr);
    bus.mem_addr    = addr;
    bus.mem_wd_data = wdata;
    bus.mem_wd_en   = wr;
    bus.mem_rd_en   = !wr;
    step();
    bus.mem_addr    = $urandom;
    bus.mem_wd_data = {$urandom, $urandom};
    lat   = 0;
    rdata = '0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (wr ? bus.mem_wd_valid : bus.mem_data_valid) begin
        lat   = k;
        rdata = bus.mem_data;
        break;
      end
    end
    if (wr) begin
      check("wr_latency", 64'(lat), 64'(WR_LAT));
      mdl[idx] = wdata;
    end else begin
      check("rd_latency", 64'(lat), 64'(RD_LAT));
      if (expect_word(idx, exp)) check("rd_data", rdata, exp);
    end
    extra = 0;
    for (int k = 0; k < hold; k++) begin
      step();
      if (bus.mem_data_valid || bus.mem_wd_valid) extra++;
    end
    check("no_second_pulse", 64'(extra), 64'd0);
    bus.mem_rd_en = 1'b0;
    bus.mem_wd_en = 1'b0;
    step();
    if (!wr) check("data_held", bus.mem_data, rdata);
  endtask

  initial begin
    int          lat;
    int          seen;
    logic [31:0] a;
    total = 0;
    bad   = 0;
    rst             = 1'b0;
    bus.mem_rd_en   = 1'b0;
    bus.mem_wd_en   = 1'b0;
    bus.mem_addr    = '0;
    bus.mem_wd_data = '0;
    step();
    step();
    check("rst_data", bus.mem_data, 64'd0);
    check("rst_rvalid", {63'd0, bus.mem_data_valid}, 64'd0);
    check("rst_wvalid", {63'd0, bus.mem_wd_valid}, 64'd0);
    rst = 1'b1;
    step();

`ifdef MEM_RESPONDER_PRELOAD_EN
    xact(1'b0, 32'h28, '0, 6);
    check("preload_w5", bus.mem_data, 64'h0000_0005_FFFF_FFFA);
`endif

    // Write then read back, including a long hold on the write enable.
    xact(1'b1, 32'h100, 64'hDEAD_BEEF_0123_4567, 5);
    xact(1'b0, 32'h100, '0, 3);
    check("wr_rd_0x100", bus.mem_data, 64'hDEAD_BEEF_0123_4567);

    // Misaligned address beyond the array wraps to word 0.
    xact(1'b1, 32'h2007, 64'h1111, 0);
    xact(1'b0, 32'h0000, '0, 0);
    check("wrap_word0", bus.mem_data, 64'h1111);

    // Simultaneous read and write: write acknowledged first, read waits for re-arm.
    bus.mem_addr    = 32'h180;
    bus.mem_wd_data = 64'h0BAD_F00D_CAFE_0001;
    bus.mem_wd_en   = 1'b1;
    bus.mem_rd_en   = 1'b1;
    step();
    lat  = 0;
    seen = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (bus.mem_data_valid) seen++;
      if (bus.mem_wd_valid) begin
        lat = k;
        break;
      end
    end
    check("both_wr_latency", 64'(lat), 64'(WR_LAT));
    mdl[word_of(32'h180)] = 64'h0BAD_F00D_CAFE_0001;
    for (int k = 0; k < 8; k++) begin
      step();
      if (bus.mem_data_valid || bus.mem_wd_valid) seen++;
    end
    check("both_no_read_yet", 64'(seen), 64'd0);
    bus.mem_wd_en = 1'b0;
    bus.mem_rd_en = 1'b0;
    step();
    xact(1'b0, 32'h180, '0, 1);
    check("both_read_after", bus.mem_data, 64'h0BAD_F00D_CAFE_0001);

    // Write aborted by reset one cycle after acceptance leaves the old word.
    xact(1'b1, 32'h40, 64'hAAAA_AAAA_AAAA_AAAA, 0);
    bus.mem_addr    = 32'h40;
    bus.mem_wd_data = 64'hBBBB_BBBB_BBBB_BBBB;
    bus.mem_wd_en   = 1'b1;
    step();
    step();
    rst           = 1'b0;
    bus.mem_wd_en = 1'b0;
    #1;
    check("abort_wvalid", {63'd0, bus.mem_wd_valid}, 64'd0);
    step();
    step();
    rst = 1'b1;
    step();
    xact(1'b0, 32'h40, '0, 0);
    check("abort_old_word", bus.mem_data, 64'hAAAA_AAAA_AAAA_AAAA);

    // Reset in the middle of a read clears outputs at once and kills the strobe.
    bus.mem_addr  = 32'h100;
    bus.mem_rd_en = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
    check("midrd_data", bus.mem_data, 64'd0);
    check("midrd_rvalid", {63'd0, bus.mem_data_valid}, 64'd0);
    check("midrd_wvalid", {63'd0, bus.mem_wd_valid}, 64'd0);
    bus.mem_rd_en = 1'b0;
    step();
    step();
    rst  = 1'b1;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (bus.mem_data_valid) seen++;
    end
    check("midrd_no_pulse", 64'(seen), 64'd0);

    // Random mix over a small word pool with random low and high address bits.
    for (int n = 0; n < 40; n++) begin
      a = (32'($urandom_range(0, 3)) << 13) | (32'($urandom_range(0, 7)) << 3) | 32'($urandom_range(0, 7));
      xact(1'($urandom_range(0, 1)), a, {$urandom, $urandom}, int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
